chan_block_rx: RTL and testbench

- Consumer end of a channel processor's block FIFO readout interface (req/ack/16-bit word).
- Pulls the words out of one channel and parses self-trigger blocks and master-trigger blocks.
- Emits header fields, a qualified 12-bit sample stream and error flags to the downstream event builder.
- Sits between one channel processor and the event builder; one instance per channel.

---
 rtl/chan_blk_pkg.sv | 41 ++++
 rtl/chan_block_rx_if.sv | 11 +
 rtl/blkrx_stats.sv | 31 +++
 rtl/chan_block_rx.sv | 213 +++++++++++++++++++++
 tb/tb_chan_block_rx.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chan_blk_pkg.sv
// Block format shared by the channel-side writer and the block receiver:
// header signatures, field positions, receiver FSM states.
package chan_blk_pkg;

    localparam logic [1:0] SIG_SELF   = 2'b10;
    localparam logic [1:0] SIG_MASTER = 2'b11;

    localparam int SIG_HI    = 15;
    localparam int SIG_LO    = 14;
    localparam int NUM_HI    = 13;
    localparam int NUM_LO    = 8;
    localparam int LEN_HI    = 7;
    localparam int LEN_LO    = 0;
    localparam int TRIG_FLAG = 15;
    localparam int TRIG_HI   = 14;
    localparam int SMP_HI    = 11;
    localparam int DERR_HI   = 15;
    localparam int DERR_LO   = 12;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        TRIG,
        DATA,
        GAP
    } state_t;

    typedef struct packed {
        logic       master;
        logic [5:0] num;
        logic [7:0] len;
    } hdr_t;

    function automatic logic hdr_ok(logic [15:0] w, int maxlen);
        logic [1:0] sig;
        sig = w[SIG_HI:SIG_LO];
        return ((sig == SIG_SELF) || (sig == SIG_MASTER))
            && (int'(w[LEN_HI:LEN_LO]) <= maxlen);
    endfunction

endpackage

// File: rtl/chan_block_rx_if.sv
// Block FIFO readout link: source presents req/din, receiver pulses ack.
interface chan_block_rx_if;

    logic        req;
    logic [15:0] din;
    logic        ack;

    modport master (output req, output din, input ack);
    modport slave  (input req, input din, output ack);

endinterface

// File: rtl/blkrx_stats.sv
// Saturating block/self/error event counters for the block receiver.
module blkrx_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc_blk,
    input  logic        inc_self,
    input  logic        inc_err,
    output logic [15:0] stat_blk,
    output logic [15:0] stat_self,
    output logic [15:0] stat_err
);

    function automatic logic [15:0] sat_inc(logic [15:0] v, logic inc);
        return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    // Clear takes priority over any increment in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            stat_blk  <= '0;
            stat_self <= '0;
            stat_err  <= '0;
        end else begin
            stat_blk  <= sat_inc(stat_blk, inc_blk);
            stat_self <= sat_inc(stat_self, inc_self);
            stat_err  <= sat_inc(stat_err, inc_err);
        end
    end

endmodule

// File: rtl/chan_block_rx.sv
// Channel block receiver: parses self/master trigger blocks from the FIFO.
// Define BLKRX_STATS_EN to add the stat_* event counters.
import chan_blk_pkg::*;

module chan_block_rx #(
    parameter int ACK_GAP = 2,
    parameter int MAXLEN  = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    chan_block_rx_if.slave src,
    output logic          hdr_valid,
    output logic          hdr_master,
    output logic [5:0]    hdr_num,
    output logic [7:0]    hdr_len,
    output logic [14:0]   hdr_trig,
    output logic          smp_valid,
    output logic [11:0]   smp_data,
    output logic          blk_done,
    output logic          hdr_err,
    output logic          trig_err,
    output logic          data_err,
    output logic          busy
`ifdef BLKRX_STATS_EN
    ,
    input  logic          stat_clr,
    output logic [15:0]   stat_blk,
    output logic [15:0]   stat_self,
    output logic [15:0]   stat_err
`endif
);

    localparam int GW = (ACK_GAP < 2) ? 1 : $clog2(ACK_GAP);
    localparam logic [GW-1:0] GAP_LAST = GW'(ACK_GAP - 1);

    state_t        state;
    state_t        state_n;
    state_t        pend;
    state_t        pend_n;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    rem;
    logic          in_blk;

    logic [15:0] din;
    hdr_t        din_h;
    logic        hdr_good;
    logic        gap_last;
    logic        last;

    logic ack_c;
    logic hdr_ld;
    logic trig_ld;
    logic hdr_valid_d;
    logic blk_done_d;
    logic hdr_err_d;
    logic trig_err_d;
    logic smp_valid_d;
    logic data_err_d;

    assign din      = src.din;
    assign din_h    = '{master: (din[SIG_HI:SIG_LO] == SIG_MASTER),
                        num:    din[NUM_HI:NUM_LO],
                        len:    din[LEN_HI:LEN_LO]};
    assign hdr_good = hdr_ok(din, MAXLEN);
    assign gap_last = (gap_cnt == GAP_LAST);
    assign last     = (rem == 8'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= IDLE;
        end else begin
            state <= state_n;
            pend  <= pend_n;
        end
    end

    // Every acked word is followed by GAP so the next din is settled
    always_comb begin
        state_n = state;
        pend_n  = pend;
        unique case (state)
            IDLE: if (src.req) state_n = HDR;
            HDR: begin
                state_n = GAP;
                if (!hdr_good)
                    pend_n = IDLE;
                else if (din_h.master)
                    pend_n = TRIG;
                else if (din_h.len == 8'd0)
                    pend_n = IDLE;
                else
                    pend_n = DATA;
            end
            TRIG: begin
                state_n = GAP;
                pend_n  = (hdr_len == 8'd0) ? IDLE : DATA;
            end
            DATA: begin
                state_n = GAP;
                pend_n  = last ? IDLE : DATA;
            end
            GAP: if (gap_last) state_n = pend;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ack_c       = 1'b0;
        hdr_ld      = 1'b0;
        trig_ld     = 1'b0;
        hdr_valid_d = 1'b0;
        blk_done_d  = 1'b0;
        hdr_err_d   = 1'b0;
        trig_err_d  = 1'b0;
        smp_valid_d = 1'b0;
        data_err_d  = 1'b0;
        unique case (state)
            HDR: begin
                ack_c = 1'b1;
                if (hdr_good) begin
                    hdr_ld      = 1'b1;
                    hdr_valid_d = !din_h.master;
                    blk_done_d  = !din_h.master
                               && (din_h.len == 8'd0);
                end else begin
                    hdr_err_d = 1'b1;
                end
            end
            TRIG: begin
                ack_c       = 1'b1;
                trig_ld     = 1'b1;
                hdr_valid_d = 1'b1;
                trig_err_d  = !din[TRIG_FLAG];
                blk_done_d  = (hdr_len == 8'd0);
            end
            DATA: begin
                ack_c       = 1'b1;
                smp_valid_d = 1'b1;
                data_err_d  = |din[DERR_HI:DERR_LO];
                blk_done_d  = last;
            end
            default: ;
        endcase
    end

    // No word is consumed while reset is held
    assign src.ack = ack_c & rst_n;
    assign busy    = (state == HDR) | in_blk | blk_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hdr_valid  <= 1'b0;
            hdr_master <= 1'b0;
            hdr_num    <= '0;
            hdr_len    <= '0;
            hdr_trig   <= '0;
            smp_valid  <= 1'b0;
            smp_data   <= '0;
            blk_done   <= 1'b0;
            hdr_err    <= 1'b0;
            trig_err   <= 1'b0;
            data_err   <= 1'b0;
            gap_cnt    <= '0;
            rem        <= '0;
            in_blk     <= 1'b0;
        end else begin
            hdr_valid <= hdr_valid_d;
            smp_valid <= smp_valid_d;
            blk_done  <= blk_done_d;
            hdr_err   <= hdr_err_d;
            trig_err  <= trig_err_d;
            data_err  <= data_err_d;
            if (smp_valid_d)
                smp_data <= din[SMP_HI:0];
            if (hdr_ld) begin
                hdr_master <= din_h.master;
                hdr_num    <= din_h.num;
                hdr_len    <= din_h.len;
                hdr_trig   <= '0;
            end
            if (trig_ld)
                hdr_trig <= din[TRIG_HI:0];
            if ((state == GAP) && !gap_last)
                gap_cnt <= gap_cnt + GW'(1);
            else
                gap_cnt <= '0;
            if (hdr_ld)
                rem <= din_h.len;
            else if (smp_valid_d)
                rem <= rem - 8'd1;
            if (blk_done_d)
                in_blk <= 1'b0;
            else if (hdr_ld)
                in_blk <= 1'b1;
        end
    end

`ifdef BLKRX_STATS_EN
    blkrx_stats u_stats (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (stat_clr),
        .inc_blk  (blk_done),
        .inc_self (blk_done & ~hdr_master),
        .inc_err  (hdr_err | trig_err | data_err),
        .stat_blk (stat_blk),
        .stat_self(stat_self),
        .stat_err (stat_err)
    );
`endif

endmodule

// File: tb/tb_chan_block_rx.sv
// Scoreboard bench for chan_block_rx: a FIFO source model feeds word
// streams, expected events are derived from the block format.
module tb_chan_block_rx;

    localparam int ACK_GAP = 2;
    localparam int MAXLEN  = 255;

    localparam logic [2:0] EV_NONE = 3'd0;
    localparam logic [2:0] EV_HERR = 3'd1;
    localparam logic [2:0] EV_HDR  = 3'd2;
    localparam logic [2:0] EV_TERR = 3'd3;
    localparam logic [2:0] EV_SMP  = 3'd4;
    localparam logic [2:0] EV_DERR = 3'd5;
    localparam logic [2:0] EV_DONE = 3'd6;

    typedef struct packed {
        logic [2:0]  k;
        logic [31:0] v;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    chan_block_rx_if bus ();

    logic        hdr_valid;
    logic        hdr_master;
    logic [5:0]  hdr_num;
    logic [7:0]  hdr_len;
    logic [14:0] hdr_trig;
    logic        smp_valid;
    logic [11:0] smp_data;
    logic        blk_done;
    logic        hdr_err;
    logic        trig_err;
    logic        data_err;
    logic        busy;
`ifdef BLKRX_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_blk;
    logic [15:0] stat_self;
    logic [15:0] stat_err;
`endif

    chan_block_rx #(.ACK_GAP(ACK_GAP), .MAXLEN(MAXLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src       (bus),
        .hdr_valid (hdr_valid),
        .hdr_master(hdr_master),
        .hdr_num   (hdr_num),
        .hdr_len   (hdr_len),
        .hdr_trig  (hdr_trig),
        .smp_valid (smp_valid),
        .smp_data  (smp_data),
        .blk_done  (blk_done),
        .hdr_err   (hdr_err),
        .trig_err  (trig_err),
        .data_err  (data_err),
        .busy      (busy)
`ifdef BLKRX_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_blk  (stat_blk),
        .stat_self (stat_self),
        .stat_err  (stat_err)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [15:0] src_q[$];
    logic [15:0] blk[$];
    ev_t         exp_q[$];
    int          ack_t[$];
    int          last_ack = -1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic got(input string tag, input logic [2:0] k,
                       input logic [31:0] v);
        ev_t e;
        if (exp_q.size() == 0)
            e = '{k: EV_NONE, v: 32'd0};
        else
            e = exp_q.pop_front();
        chk(tag, {29'd0, k, v}, {29'd0, e.k, e.v});
    endtask

    // Source FIFO: word leaves on the ack edge, next word shows up later
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.ack && (src_q.size() != 0))
            void'(src_q.pop_front());
    end

    always @(negedge clk) begin
        bus.req = (src_q.size() != 0);
        bus.din = (src_q.size() != 0) ? src_q[0] : 16'h0000;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ack) begin
                if (last_ack >= 0)
                    chk("ack_gap", 64'((cyc - last_ack) >= ACK_GAP + 1), 64'd1);
                last_ack = cyc;
                ack_t.push_back(cyc);
            end
            if (hdr_err)
                got("hdr_err", EV_HERR, 32'd0);
            if (hdr_valid)
                got("hdr", EV_HDR, {2'b0, hdr_master, hdr_num, hdr_len, hdr_trig});
            if (trig_err)
                got("trig_err", EV_TERR, 32'd0);
            if (smp_valid)
                got("smp", EV_SMP, {20'd0, smp_data});
            if (data_err)
                got("data_err", EV_DERR, 32'd0);
            if (blk_done)
                got("blk_done", EV_DONE, 32'd0);
        end
    end

    // Expected events straight from the block format, then queue the words
    task automatic send();
        int i;
        logic [15:0] h;
        logic [15:0] t;
        logic [15:0] d;
        logic [14:0] tr;
        i = 0;
        while (i < blk.size()) begin
            h = blk[i];
            i++;
            if (!h[15] || (int'(h[7:0]) > MAXLEN)) begin
                exp_q.push_back('{k: EV_HERR, v: 32'd0});
                continue;
            end
            t  = 16'h0;
            tr = 15'h0;
            if (h[14]) begin
                t  = blk[i];
                i++;
                tr = t[14:0];
            end
            exp_q.push_back('{k: EV_HDR, v: {2'b0, h[14], h[13:8], h[7:0], tr}});
            if (h[14] && !t[15])
                exp_q.push_back('{k: EV_TERR, v: 32'd0});
            for (int k = 0; k < int'(h[7:0]); k++) begin
                d = blk[i];
                i++;
                exp_q.push_back('{k: EV_SMP, v: {20'd0, d[11:0]}});
                if (d[15:12] != 4'h0)
                    exp_q.push_back('{k: EV_DERR, v: 32'd0});
            end
            exp_q.push_back('{k: EV_DONE, v: 32'd0});
        end
        foreach (blk[j])
            src_q.push_back(blk[j]);
        blk.delete();
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ((exp_q.size() == 0) && (src_q.size() == 0) && !busy)
                break;
        end
        repeat (8) @(negedge clk);
        chk(tag, 64'(exp_q.size()), 64'd0);
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    function automatic logic [63:0] all_out();
        return {14'd0, hdr_valid, hdr_master, hdr_num, hdr_len, hdr_trig,
                smp_valid, smp_data, blk_done, hdr_err, trig_err,
                data_err, busy, bus.ack};
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        logic        seen;

        bus.req = 1'b0;
        bus.din = 16'h0;
        repeat (4) @(negedge clk);
        chk("reset_out", all_out(), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_out", all_out(), 64'd0);

        // Self block, acks ACK_GAP+1 apart
        ack_t.delete();
        blk = '{16'h8503, 16'h0011, 16'h0022, 16'h0FFF};
        send();
        drain("self3");
        chk("ack_cnt", 64'(ack_t.size()), 64'd4);
        for (int i = 1; i < 4 && i < ack_t.size(); i++)
            chk("ack_space", 64'(ack_t[i] - ack_t[i-1]), 64'(ACK_GAP + 1));

        blk = '{16'hC102, 16'h9234, 16'h0001, 16'h0002};
        send();
        drain("master2");

        blk = '{16'hC700, 16'h8001};
        send();
        drain("master0");

        blk = '{16'h8900};
        send();
        drain("self0");

        blk = '{16'h0ABC, 16'h8402, 16'h0AAA, 16'h0555};
        send();
        drain("garbage");

        blk = '{16'hC302, 16'h1234, 16'h1005, 16'h0007};
        send();
        drain("errs");

        // Back-to-back blocks queued together
        blk = '{16'h8101, 16'h0123, 16'hC000, 16'h8FFF, 16'h8202,
                16'hF0F0, 16'h0456};
        send();
        drain("b2b");

        // Longest block must not end early
        blk.push_back(16'h82FF);
        for (int i = 0; i < 255; i++) begin
            w = 16'($urandom_range(0, 4095));
            if ($urandom_range(0, 7) == 0)
                w[15:12] = 4'h3;
            blk.push_back(w);
        end
        send();
        drain("len255");

        // Reset during the 2nd sample of an L=10 block
        blk.push_back(16'h8A0A);
        for (int i = 0; i < 10; i++)
            blk.push_back(16'h0100 + 16'(i));
        send();
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (smp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_first_smp", {63'd0, seen}, 64'd1);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.ack) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_second_ack", {63'd0, seen}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out", all_out(), 64'd0);
        src_q.delete();
        exp_q.delete();
        last_ack = -1;
        rst_n = 1'b1;
        blk = '{16'h8503, 16'h0011, 16'h0022, 16'h0FFF};
        send();
        drain("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
